// File: rtl/mips_boot_loader.sv
// Boot loader for the multi-cycle mips core: receives a length-prefixed, checksummed
// byte image, writes it word-by-word into instruction memory, then releases the core.
module mips_boot_loader #(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_words
);

  localparam int HOLD_W = $clog2(RST_HOLD + 2);
  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);
  localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_HOLD   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [7:0]          hdr_hi_r;
  logic [7:0]          acc_r;
  logic [ADDR_W:0]     word_count_r;
  logic [1:0]          byte_idx_r;
  logic [23:0]         asm_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic                take_s, word_done_s, last_word_s;
  logic [15:0]         n_full_s;

  // Byte-stream handshake; reload blocks acceptance so it wins over a pending byte
  always_comb begin
    rx_ready = 1'b0;
    if (reload) begin
      rx_ready = 1'b0;
    end else begin
      case (state_r)
        S_HDR_HI, S_HDR_LO, S_DATA, S_CHK, S_ERR: rx_ready = 1'b1;
        default:                                  rx_ready = 1'b0;
      endcase
    end
  end

  assign take_s      = rx_valid && rx_ready;
  assign n_full_s    = {hdr_hi_r, rx_data};
  assign word_done_s = take_s && (state_r == S_DATA) && (byte_idx_r == 2'd3);
  assign last_word_s = ((loaded_words + ONE_WORD) == word_count_r);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    if (reload) begin
      state_s = S_HDR_HI;
    end else begin
      case (state_r)
        S_HDR_HI: begin
          if (take_s) state_s = S_HDR_LO;
          else        state_s = state_r;
        end
        S_HDR_LO: begin
          if (!take_s)                        state_s = state_r;
          else if ({1'b0, n_full_s} > MAX_WORDS) state_s = S_ERR;
          else if (n_full_s == 16'd0)          state_s = S_CHK;
          else                                 state_s = S_DATA;
        end
        S_DATA: begin
          if (word_done_s && last_word_s) state_s = S_CHK;
          else                            state_s = state_r;
        end
        S_CHK: begin
          if (!take_s)                state_s = state_r;
          else if (rx_data == acc_r)  state_s = S_HOLD;
          else                        state_s = S_ERR;
        end
        S_HOLD: begin
          if (hold_cnt_r == HOLD_W'(RST_HOLD)) state_s = S_RUN;
          else                                 state_s = state_r;
        end
        S_RUN:   state_s = S_RUN;
        S_ERR:   state_s = S_ERR;
        default: state_s = S_HDR_HI;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_HDR_HI;
    else        state_r <= state_s;
  end

  // Header capture, word assembly, checksum accumulation and hold counting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_hi_r     <= 8'd0;
      acc_r        <= 8'd0;
      word_count_r <= '0;
      byte_idx_r   <= 2'd0;
      asm_r        <= 24'd0;
      hold_cnt_r   <= '0;
      loaded_words <= '0;
    end else if (reload) begin
      acc_r        <= 8'd0;
      byte_idx_r   <= 2'd0;
      hold_cnt_r   <= '0;
      loaded_words <= '0;
    end else begin
      if (take_s && (state_r == S_HDR_HI || state_r == S_HDR_LO || state_r == S_DATA))
        acc_r <= acc_r + rx_data;
      case (state_r)
        S_HDR_HI: if (take_s) hdr_hi_r <= rx_data;
        S_HDR_LO: begin
          if (take_s) begin
            word_count_r <= n_full_s[ADDR_W:0];
            byte_idx_r   <= 2'd0;
          end
        end
        S_DATA: begin
          if (take_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            asm_r      <= {asm_r[15:0], rx_data};
            if (byte_idx_r == 2'd3) loaded_words <= loaded_words + ONE_WORD;
          end
        end
        S_HOLD:  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        default: hold_cnt_r <= hold_cnt_r;
      endcase
    end
  end

  // Registered outputs: write strobe fires on the edge after a word's last byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we   <= word_done_s;
      cpu_reset <= (state_s != S_RUN);
      done      <= (state_s == S_RUN);
      error     <= (state_s == S_ERR);
      if (reload) begin
        imem_addr <= '0;
      end else if (word_done_s) begin
        imem_addr  <= loaded_words[ADDR_W-1:0];
        imem_wdata <= {asm_r, rx_data};
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized self-checking bench for mips_boot_loader: a byte-queue model derives every
// output from the accepted bytes and is compared against the DUT on each falling edge.
module tb_mips_boot_loader;
  localparam int ADDR_W   = 10;
  localparam int RST_HOLD = 4;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              reload = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_ready, imem_we, cpu_reset, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   loaded_words;

  mips_boot_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .reset(reset), .reload(reload), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the image is just the list of accepted bytes; everything else follows from it.
  bq_t         mq;
  int          since_chk = 0;
  bit          we_e = 1'b0;
  int          ad_e = 0;
  logic [31:0] wd_e = 32'd0;

  function automatic logic [7:0] sum_first(input bq_t q, input int cnt);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < cnt; i++) s = s + q[i];
    return s;
  endfunction

  function automatic int m_n();
    if (mq.size() < 2) return -1;
    return int'({mq[0], mq[1]});
  endfunction

  // 0 = still loading, 1 = image good (hold/run), 2 = failed
  function automatic int m_mode();
    int n = m_n();
    if (n < 0) return 0;
    if (n > (1 << ADDR_W)) return 2;
    if (mq.size() < 3 + 4 * n) return 0;
    return (mq[mq.size() - 1] == sum_first(mq, mq.size() - 1)) ? 1 : 2;
  endfunction

  function automatic int m_words();
    int n = m_n();
    int w;
    if (n < 0 || n > (1 << ADDR_W)) return 0;
    w = (mq.size() - 2) / 4;
    return (w < n) ? w : n;
  endfunction

  always @(posedge clk or negedge reset) begin
    int md, n, s;
    we_e = 1'b0;
    if (!reset || reload) begin
      mq.delete();
      since_chk = 0;
    end else begin
      md = m_mode();
      if (md == 1) begin
        since_chk++;
      end else if (md == 0 && rx_valid) begin
        mq.push_back(rx_data);
        if (m_mode() != 0) since_chk = 0;
        n = m_n();
        s = mq.size();
        if (n > 0 && n <= (1 << ADDR_W) && s >= 6 && s <= 2 + 4 * n && ((s - 2) % 4) == 0) begin
          we_e = 1'b1;
          ad_e = (s - 2) / 4 - 1;
          wd_e = {mq[s-4], mq[s-3], mq[s-2], mq[s-1]};
        end
      end
    end
  end

  always @(negedge clk) begin
    int md;
    bit run;
    md  = m_mode();
    run = (md == 1) && (since_chk >= RST_HOLD + 1);
    check("rx_ready", 32'(rx_ready), 32'(!reload && md != 1));
    check("imem_we", 32'(imem_we), 32'(we_e));
    if (we_e) begin
      check("imem_addr", 32'(imem_addr), 32'(ad_e));
      check("imem_wdata", imem_wdata, wd_e);
    end
    check("cpu_reset", 32'(cpu_reset), 32'(!run));
    check("done", 32'(done), 32'(run));
    check("error", 32'(error), 32'(md == 2));
    check("loaded_words", 32'(loaded_words), 32'(m_words()));
  end

  // Write log used by the literal end-of-scenario checks
  logic [31:0] mem_log [0:15];
  int          n_writes = 0;
  int          writes_at1 = 0;
  always @(negedge clk) begin
    if (imem_we) begin
      if (imem_addr < 16) mem_log[imem_addr] = imem_wdata;
      n_writes++;
      if (imem_addr == 1) writes_at1++;
    end
  end

  function automatic bq_t make_image(input wq_t w, input logic [7:0] delta);
    bq_t q;
    q.push_back(8'(w.size() >> 8));
    q.push_back(8'(w.size()));
    foreach (w[i]) begin
      q.push_back(w[i][31:24]); q.push_back(w[i][23:16]);
      q.push_back(w[i][15:8]);  q.push_back(w[i][7:0]);
    end
    q.push_back(sum_first(q, q.size()) + delta);
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1; rx_data = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = rx_ready;
      @(posedge clk); #1;
    end
    check("byte_accept", 32'(ok), 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t q, input int cnt, input bit gaps);
    for (int i = 0; i < cnt; i++) send_byte(q[i], gaps);
  endtask

  task automatic wait_release();
    int k = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      k = i; seen = done;
    end
    check("release_latency", 32'(k), 32'(RST_HOLD + 1));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  initial begin
    bq_t img, bad, q;
    wq_t w;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_loaded", 32'(loaded_words), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Good two-word image, one byte per cycle
    w = {32'h20080005, 32'hAC080000};
    img = make_image(w, 8'd0);
    check("image_checksum", 32'(img[img.size()-1]), 32'h000000E3);
    n_writes = 0;
    send_bytes(img, img.size(), 1'b0);
    wait_release();
    check("good_w0", mem_log[0], 32'h20080005);
    check("good_w1", mem_log[1], 32'hAC080000);
    check("good_nwrites", 32'(n_writes), 32'd2);
    check("good_loaded", 32'(loaded_words), 32'd2);

    // In RUN a waiting byte is never consumed
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (8) @(posedge clk); #1;
    check("run_done", 32'(done), 32'd1);
    check("run_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;
    pulse_reload();
    check("reload_done", 32'(done), 32'd0);

    // Bad checksum
    bad = img;
    bad[bad.size()-1] = 8'h80;
    send_bytes(bad, bad.size(), 1'b0);
    @(posedge clk); #1;
    check("bad_error", 32'(error), 32'd1);
    check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'hA5, 1'b0);
    pulse_reload();
    check("bad_reload_error", 32'(error), 32'd0);

    // Empty image
    n_writes = 0;
    q = {8'h00, 8'h00, 8'h00};
    send_bytes(q, 3, 1'b0);
    wait_release();
    check("empty_nwrites", 32'(n_writes), 32'd0);
    pulse_reload();

    // Oversized header
    q = {8'h04, 8'h01};
    send_bytes(q, 2, 1'b0);
    check("big_error", 32'(error), 32'd1);
    send_byte(8'h12, 1'b0);
    check("big_nwrites", 32'(n_writes), 32'd0);
    pulse_reload();

    // Same good image with random gaps
    mem_log[0] = 32'd0; mem_log[1] = 32'd0;
    send_bytes(img, img.size(), 1'b1);
    wait_release();
    check("gap_w0", mem_log[0], 32'h20080005);
    check("gap_w1", mem_log[1], 32'hAC080000);
    pulse_reload();

    // Random images
    for (int r = 0; r < 4; r++) begin
      w.delete();
      repeat ($urandom_range(1, 8)) w.push_back($urandom);
      q = make_image(w, 8'd0);
      send_bytes(q, q.size(), 1'b1);
      wait_release();
      foreach (w[i]) check("rand_word", mem_log[i], w[i]);
      pulse_reload();
    end

    // Reload mid-word, coinciding with a presented byte
    n_writes = 0; writes_at1 = 0;
    send_bytes(img, 8, 1'b0);
    rx_valid = 1'b1; rx_data = img[8]; reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0; rx_valid = 1'b0;
    check("midword_at1", 32'(writes_at1), 32'd0);
    check("midword_nwrites", 32'(n_writes), 32'd1);
    check("midword_loaded", 32'(loaded_words), 32'd0);
    w = {32'h11223344, 32'h55667788};
    q = make_image(w, 8'd0);
    send_bytes(q, q.size(), 1'b0);
    wait_release();
    check("fresh_w0", mem_log[0], 32'h11223344);
    check("fresh_w1", mem_log[1], 32'h55667788);
    pulse_reload();

    // Asynchronous reset in the middle of the data phase
    send_bytes(img, 7, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("arst_we", 32'(imem_we), 32'd0);
    check("arst_loaded", 32'(loaded_words), 32'd0);
    check("arst_ready", 32'(rx_ready), 32'd1);
    check("arst_addr", 32'(imem_addr), 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    mem_log[0] = 32'd0; mem_log[1] = 32'd0;
    send_bytes(img, img.size(), 1'b1);
    wait_release();
    check("arst_w0", mem_log[0], 32'h20080005);
    check("arst_w1", mem_log[1], 32'hAC080000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
